// File: rtl/drum_line_access_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | drum_line_access_if : word-transfer request/response bus           |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface drum_line_access_if #(
  parameter int WORD_BITS = 29
);
  logic                 req;
  logic                 op;
  logic [6:0]           addr;
  logic [WORD_BITS-1:0] wdata;
  logic                 ack;
  logic                 err;
  logic                 busy;
  logic [WORD_BITS-1:0] rdata;

  modport master (output req, op, addr, wdata, input ack, err, busy, rdata);
  modport slave  (input req, op, addr, wdata, output ack, err, busy, rdata);
endinterface
`default_nettype wire

// File: rtl/drum_line_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | drum_line_access : serial word read/write on a recirculating drum  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module drum_line_access #(
  parameter int WORD_BITS = 29,
  parameter int WORDS     = 108
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_bit,
  output logic               wr_bit,
  output logic [4:0]         bit_time,
  output logic [6:0]         word_time,
  drum_line_access_if.slave  bus
);

  localparam logic [4:0] LAST_BIT  = 5'(WORD_BITS - 1);
  localparam logic [6:0] LAST_WORD = 7'(WORDS - 1);
  localparam logic [7:0] NUM_WORDS = 8'(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state, state_nx;
  logic                   op_q;
  logic [6:0]             addr_q;
  logic [WORD_BITS-1:0]   wdata_q;
  logic                   err_q;
  logic [WORD_BITS-2:0]   shreg;
  logic [WORD_BITS-1:0]   rdata_q;
  logic                   addr_bad;
  logic [6:0]             prev_addr;
  logic                   last_bit;

  assign addr_bad  = {1'b0, bus.addr} >= NUM_WORDS;
  assign prev_addr = (addr_q == 7'd0) ? LAST_WORD : addr_q - 7'd1;
  assign last_bit  = (bit_time == LAST_BIT);

  // Free-running drum position; defines which bit rd_bit carries now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_time  <= 5'd0;
      word_time <= 7'd0;
    end else if (last_bit) begin
      bit_time  <= 5'd0;
      word_time <= (word_time == LAST_WORD) ? 7'd0 : word_time + 7'd1;
    end else begin
      bit_time  <= bit_time + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= 1'b0;
      addr_q  <= 7'd0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      shreg   <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.req) begin
        err_q <= addr_bad;
        if (!addr_bad) begin
          op_q    <= bus.op;
          addr_q  <= bus.addr;
          wdata_q <= bus.wdata;
        end
      end
      if (state == XFER) begin
        shreg <= {rd_bit, shreg[WORD_BITS-2:1]};
        // Final bit bypasses the shifter so rdata is valid alongside ack.
        if (last_bit && !op_q) begin
          rdata_q <= {rd_bit, shreg};
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.req) state_nx = addr_bad ? DONE : WAIT;
      // Arm only at the end of the preceding word so a transfer is never partial.
      WAIT: if (last_bit && word_time == prev_addr) state_nx = XFER;
      XFER: if (last_bit) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_bit = rd_bit;
    if (state == XFER && op_q) begin
      wr_bit = wdata_q[bit_time];
    end
  end

  assign bus.ack   = (state == DONE);
  assign bus.err   = (state == DONE) && err_q;
  assign bus.busy  = (state != IDLE);
  assign bus.rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_drum_line_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_drum_line_access : random transactions against a drum-line model|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_drum_line_access;

  localparam int WB = 29;
  localparam int NW = 108;
  localparam int L  = WB * NW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_bit;
  logic          wr_bit;
  logic [4:0]    bit_time;
  logic [6:0]    word_time;

  drum_line_access_if #(.WORD_BITS(WB)) bus ();

  drum_line_access #(.WORD_BITS(WB), .WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_bit    (rd_bit),
    .wr_bit    (wr_bit),
    .bit_time  (bit_time),
    .word_time (word_time),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Drum track: position is simply cycles since reset release.
  logic [WB-1:0] track    [NW];
  logic [WB-1:0] init_val [NW];
  logic [WB-1:0] exp_mem  [NW];
  logic          load = 1'b1;
  int            cyc;

  assign rd_bit = track[(cyc / WB) % NW][cyc % WB];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      if (load) begin
        for (int i = 0; i < NW; i++) track[i] <= init_val[i];
      end
    end else begin
      track[(cyc / WB) % NW][cyc % WB] <= wr_bit;
      cyc <= cyc + 1;
    end
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [WB-1:0] last_rd = '0;
  int            last_ack = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int line_diffs();
    int n = 0;
    for (int i = 0; i < NW; i++) if (track[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Expected first XFER cycle for a request accepted in cycle c.
  function automatic int xfer_start(input int c, input int a);
    return c + 2 + ((((a * WB) - (c + 2)) % L) + L) % L;
  endfunction

  task automatic run_txn(input logic op_i, input logic [6:0] a, input logic [WB-1:0] d,
                         input bit hold, input bit late, input bit inject);
    int c, t, ack_exp, n, nmis, nbusy;
    bit seen, bad;
    c = late ? cyc + 1 : cyc;
    bus.req = 1'b1; bus.op = op_i; bus.addr = a; bus.wdata = d;
    bad = (int'(a) >= NW);
    t = bad ? c + 1 : xfer_start(c, int'(a));
    ack_exp = bad ? c + 1 : t + WB;
    seen = 0; nmis = 0; nbusy = 0; n = c;
    for (int k = 0; k < 2 * L + 64 && !seen; k++) begin
      @(negedge clk);
      n = cyc;
      if (n > c) bus.req = 1'b0;
      if (inject && n > c && n < ack_exp - 1 && $urandom_range(0, 199) == 0) begin
        bus.req = 1'b1; bus.op = 1'($urandom); bus.addr = 7'($urandom);
        bus.wdata = WB'($urandom);
      end
      if (n > c && !(op_i && !bad && n >= t && n < t + WB) && wr_bit !== rd_bit) nmis++;
      if (bus.ack) begin
        seen = 1;
        check_val("ack_cycle", n, ack_exp);
        check_val("err", bus.err, bad);
        check_val("busy_done", bus.busy, 1);
        check_val("bit_time", bit_time, n % WB);
        check_val("word_time", word_time, (n / WB) % NW);
        if (!op_i && !bad) begin
          check_val("rdata", bus.rdata, exp_mem[a]);
          last_rd = exp_mem[a];
        end else begin
          check_val("rdata_hold", bus.rdata, last_rd);
        end
        if (op_i && !bad) exp_mem[a] = d;
        check_val("line", line_diffs(), 0);
        last_ack = n;
        if (hold) bus.req = 1'b1;
      end else if (n > c && !bus.busy) begin
        nbusy++;
      end
    end
    check_val("ack_seen", seen, 1);
    check_val("passthru", nmis, 0);
    check_val("busy_wait", nbusy, 0);
    if (!hold) begin
      @(negedge clk);
      check_val("idle_busy", bus.busy, 0);
      check_val("ack_pulse", bus.ack, 0);
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_ack", bus.ack, 0);
    check_val("rst_err", bus.err, 0);
    check_val("rst_rdata", bus.rdata, 0);
    check_val("rst_bit", bit_time, 0);
    check_val("rst_word", word_time, 0);
    check_val("rst_thru", wr_bit, rd_bit);
  endtask

  initial begin
    logic [6:0]    a;
    logic [WB-1:0] d;
    int            c, t, nack;
    bus.req = 1'b0; bus.op = 1'b0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < NW; i++) begin
      init_val[i] = WB'($urandom);
      exp_mem[i]  = init_val[i];
    end
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    #1;
    load = 1'b0;
    check_val("rel_bit", bit_time, 0);
    check_val("rel_word", word_time, 0);

    // Write word 0 straight out of reset, then read it back.
    run_txn(1'b1, 7'd0, 29'h15555555, 0, 0, 0);
    check_val("first_ack", last_ack, 3161);
    run_txn(1'b0, 7'd0, '0, 0, 0, 0);
    check_val("word0_replay", last_rd, 29'h15555555);

    run_txn(1'b1, 7'd5, 29'h0ABCDEF, 0, 0, 0);
    run_txn(1'b0, 7'd5, '0, 0, 0, 0);
    check_val("word5_read", last_rd, 29'h0ABCDEF);

    // Rejected address, and one at the very top of the 7-bit range.
    run_txn(1'b1, 7'd108, 29'h1FFFFFFF, 0, 0, 0);
    run_txn(1'b0, 7'd127, '0, 0, 0, 1);

    // Back-to-back writes with req held through the first ack.
    run_txn(1'b1, 7'd107, WB'($urandom), 1, 0, 0);
    run_txn(1'b1, 7'd0, WB'($urandom), 0, 1, 0);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      run_txn(1'($urandom), 7'($urandom_range(0, 115)), WB'($urandom), 0, 0, 1);
    end
    run_txn(1'b0, 7'd107, '0, 0, 0, 0);

    // Reset in the middle of a write: only bits 0..9 land.
    a = 7'($urandom_range(1, 106));
    d = WB'($urandom);
    c = cyc;
    bus.req = 1'b1; bus.op = 1'b1; bus.addr = a; bus.wdata = d;
    t = xfer_start(c, int'(a));
    nack = 0;
    while (cyc < t + 10) begin
      @(negedge clk);
      bus.req = 1'b0;
      if (bus.ack) nack++;
    end
    check_val("rst_no_ack", nack, 0);
    rst_n = 1'b0;
    #1;
    exp_mem[a] = {exp_mem[a][WB-1:10], d[9:0]};
    last_rd = '0;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    #1;
    check_val("rel2_bit", bit_time, 0);
    check_val("rel2_word", word_time, 0);
    check_val("line_after_rst", line_diffs(), 0);
    nack = 0;
    repeat (4 * WB) begin
      @(negedge clk);
      if (bus.ack) nack++;
    end
    check_val("rst_no_late_ack", nack, 0);
    run_txn(1'b0, a, '0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
